// File: rtl/output_collector.sv
// -----------------------------------------------------------------------------
// output_collector
//
// Receiver end of the 2x2 systolic-array data path. Each column of the array
// delivers its two results serially (row 1 first); column 2 trails column 1 by
// one cycle because of the input skew. This block reassembles those beats into
// a parallel 2x2 matrix, holds it, and offers it downstream with valid/ready.
// Any beat arriving with no slot to land in is dropped and flagged.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   start       one-cycle pulse: clear everything and arm a new collection
//   col1_valid  column 1 beat valid
//   col1_data   column 1 result word (row 1, then row 2)
//   col2_valid  column 2 beat valid
//   col2_data   column 2 result word (row 1, then row 2)
//   out_ready   downstream accepts the matrix
//   c11..c22    assembled result matrix (registered)
//   out_valid   matrix complete and held
//   busy        high while collecting
//   overflow    sticky: a beat was dropped since the last start/reset
// -----------------------------------------------------------------------------
module output_collector #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              col1_valid,
  input  logic [DATA_W-1:0] col1_data,
  input  logic              col2_valid,
  input  logic [DATA_W-1:0] col2_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c21,
  output logic [DATA_W-1:0] c22,
  output logic              out_valid,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [1:0] CNT_FULL = 2'd2;

  state_t     state;
  logic [1:0] cnt1;
  logic [1:0] cnt2;

  // A column captures only while it still has a free slot; anything else
  // on that column is a dropped beat.
  logic       cap1;
  logic       cap2;
  logic [1:0] cnt1_nxt;
  logic [1:0] cnt2_nxt;

  always_comb begin
    cap1     = col1_valid && (cnt1 != CNT_FULL);
    cap2     = col2_valid && (cnt2 != CNT_FULL);
    cnt1_nxt = cnt1 + {1'b0, cap1};
    cnt2_nxt = cnt2 + {1'b0, cap2};
  end

  // NOTE: every register here is written with <= so all of them sample the
  // same pre-edge values; blocking assignments would let later statements see
  // already-updated state and reorder the behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the matrix registers are reset too -- downstream may sample
      // c11..c22 in IDLE, so they must come out of reset at a known 0.
      state     <= IDLE;
      cnt1      <= 2'd0;
      cnt2      <= 2'd0;
      c11       <= '0;
      c12       <= '0;
      c21       <= '0;
      c22       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else if (start) begin
      // start overrides everything, including a pending out_ready in DONE;
      // beats presented alongside it are ignored entirely.
      state     <= COLLECT;
      cnt1      <= 2'd0;
      cnt2      <= 2'd0;
      c11       <= '0;
      c12       <= '0;
      c21       <= '0;
      c22       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Not armed: every beat is a drop. The previous matrix stays put.
          if (col1_valid || col2_valid) overflow <= 1'b1;
        end

        COLLECT: begin
          if (cap1) begin
            if (cnt1 == 2'd0) c11 <= col1_data;
            else              c21 <= col1_data;
          end
          if (cap2) begin
            if (cnt2 == 2'd0) c12 <= col2_data;
            else              c22 <= col2_data;
          end
          cnt1 <= cnt1_nxt;
          cnt2 <= cnt2_nxt;

          if ((col1_valid && !cap1) || (col2_valid && !cap2)) overflow <= 1'b1;

          // Completion looks at the post-capture counts so out_valid rises on
          // the same edge that lands the last word.
          if (cnt1_nxt == CNT_FULL && cnt2_nxt == CNT_FULL) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end

        DONE: begin
          if (col1_valid || col2_valid) overflow <= 1'b1;
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// -----------------------------------------------------------------------------
// tb_output_collector
//
// Drives output_collector with directed and randomized beat streams and
// compares every cycle against a queue-based model: each column's accepted
// words sit in a queue (at most two), the matrix is read straight from the
// queues, and out_valid/busy/overflow are plain flags.
// -----------------------------------------------------------------------------
module tb_output_collector;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         col1_valid;
  logic [W-1:0] col1_data;
  logic         col2_valid;
  logic [W-1:0] col2_data;
  logic         out_ready;
  logic [W-1:0] c11, c12, c21, c22;
  logic         out_valid;
  logic         busy;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  output_collector #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .col1_valid (col1_valid),
    .col1_data  (col1_data),
    .col2_valid (col2_valid),
    .col2_data  (col2_data),
    .out_ready  (out_ready),
    .c11        (c11),
    .c12        (c12),
    .c21        (c21),
    .c22        (c22),
    .out_valid  (out_valid),
    .busy       (busy),
    .overflow   (overflow)
  );

  logic [4*W+2:0] dut_vec;
  assign dut_vec = {c11, c12, c21, c22, out_valid, busy, overflow};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  bit           m_coll;
  bit           m_valid;
  bit           m_ovf;

  function automatic logic [4*W+2:0] model_vec();
    logic [W-1:0] e [4];
    e = '{default: '0};
    if (q1.size() > 0) e[0] = q1[0];
    if (q2.size() > 0) e[1] = q2[0];
    if (q1.size() > 1) e[2] = q1[1];
    if (q2.size() > 1) e[3] = q2[1];
    return {e[0], e[1], e[2], e[3], m_valid, m_coll, m_ovf};
  endfunction

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_coll  = 0;
    m_valid = 0;
    m_ovf   = 0;
  endtask

  task automatic model_apply(input bit s, input bit v1, input logic [W-1:0] d1,
                             input bit v2, input logic [W-1:0] d2, input bit r);
    if (s) begin
      q1.delete();
      q2.delete();
      m_coll  = 1;
      m_valid = 0;
      m_ovf   = 0;
    end else if (m_coll) begin
      if (v1) begin
        if (q1.size() < 2) q1.push_back(d1);
        else               m_ovf = 1;
      end
      if (v2) begin
        if (q2.size() < 2) q2.push_back(d2);
        else               m_ovf = 1;
      end
      if (q1.size() == 2 && q2.size() == 2) begin
        m_coll  = 0;
        m_valid = 1;
      end
    end else begin
      if (v1 || v2) m_ovf = 1;
      if (m_valid && r) m_valid = 0;
    end
  endtask

  // One clock cycle: present inputs, advance model and DUT, settle at edge+1.
  task automatic step(input bit s, input bit v1, input logic [W-1:0] d1,
                      input bit v2, input logic [W-1:0] d2, input bit r);
    start      = s;
    col1_valid = v1;
    col1_data  = d1;
    col2_valid = v2;
    col2_data  = d2;
    out_ready  = r;
    model_apply(s, v1, d1, v2, d2, r);
    @(posedge clk);
    #1;
    start      = 1'b0;
    col1_valid = 1'b0;
    col2_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return $urandom() | 32'h8000_0000;  // keeps random words distinct from 9
  endfunction

  typedef struct {
    bit           s;
    bit           v1;
    logic [W-1:0] d1;
    bit           v2;
    logic [W-1:0] d2;
    bit           r;
    bit           ov;   // out_valid expected after this cycle's edge
  } beat_t;

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    col1_valid = 1'b0;
    col1_data  = '0;
    col2_valid = 1'b0;
    col2_data  = '0;
    out_ready  = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 32'h1234, 1, 32'h5678, 1);  // beats in IDLE are drops
    n_checks++;
    if (dut_vec !== model_vec() || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_drop: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_nominal();
    beat_t tbl [5];
    tbl = '{'{1, 0, 0, 0, 0, 1, 0},
            '{0, 1, 5, 0, 0, 1, 0},
            '{0, 1, 7, 1, 6, 1, 0},
            '{0, 0, 0, 1, 8, 1, 1},
            '{0, 0, 0, 0, 0, 1, 0}};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].s, tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].r);
      n_checks++;
      if (dut_vec !== model_vec() || out_valid !== tbl[i].ov) begin
        n_fail++;
        $display("FAIL nominal cycle %0d: got %h want %h (out_valid want %0b)",
                 i + 1, dut_vec, model_vec(), tbl[i].ov);
      end
    end
    n_checks++;
    if ({c11, c12, c21, c22} !== {32'd5, 32'd6, 32'd7, 32'd8} ||
        busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_matrix: got %h %h %h %h busy=%0b ovf=%0b want 5 6 7 8 busy=0 ovf=0",
               c11, c12, c21, c22, busy, overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = rnd_word();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, w[0], 0, 0, 0);
    step(0, 1, w[1], 1, w[2], 0);
    step(0, 0, 0, 1, w[3], 0);
    // out_valid is now up; keep out_ready low for five cycles.
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || {c11, c21, c12, c22} !== {w[0], w[1], w[2], w[3]} ||
          dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL backpressure_hold %0d: got %h want %h", i, dut_vec, model_vec());
      end
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL backpressure_release: got %h want %h", dut_vec, model_vec());
    end
    step(0, 0, 0, 0, 0, 1);  // out_ready with out_valid low: no effect
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL ready_idle: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_unskewed();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL unskewed_early: got out_valid=%0b busy=%0b want 0 1", out_valid, busy);
    end
    step(0, 1, 32'h1, 1, 32'h2, 0);
    n_checks++;
    if (out_valid !== 1'b1 || c11 !== 32'hFFFF_FFFF || c12 !== 32'h8000_0000 ||
        c21 !== 32'h1 || c22 !== 32'h2 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL unskewed_matrix: got %h want %h", dut_vec, model_vec());
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    logic [W-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = rnd_word();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, w[0], 0, 0, 0);
    step(0, 1, w[1], 1, w[2], 0);
    step(0, 1, 32'd9, 1, w[3], 0);  // third col1 beat: no slot left
    n_checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b1 ||
        {c11, c21, c12, c22} !== {w[0], w[1], w[2], w[3]} || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL overflow_collect: got %h want %h", dut_vec, model_vec());
    end
    step(0, 0, 0, 1, 32'd9, 0);     // beat during DONE
    n_checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL overflow_done: got %h want %h", dut_vec, model_vec());
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %h want %h", dut_vec, model_vec());
    end
    step(1, 1, 32'd9, 1, 32'd9, 0); // valids in the start cycle are ignored
    n_checks++;
    if (overflow !== 1'b0 || busy !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL overflow_clear: got %h want %h", dut_vec, model_vec());
    end
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_restart();
    logic [W-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = rnd_word();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, rnd_word(), 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    n_checks++;
    if ({c11, c12, c21, c22} !== '0 || busy !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL restart_clear: got %h want %h", dut_vec, model_vec());
    end
    step(0, 1, w[0], 0, 0, 0);
    step(0, 1, w[1], 1, w[2], 0);
    step(0, 0, 0, 1, w[3], 0);
    n_checks++;
    if ({c11, c21, c12, c22} !== {w[0], w[1], w[2], w[3]} || out_valid !== 1'b1 ||
        dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL restart_matrix: got %h want %h", dut_vec, model_vec());
    end
    step(1, 0, 0, 0, 0, 1);         // start beats out_ready in DONE
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL start_vs_ready: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = rnd_word();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, rnd_word(), 0, 0, 0);
    n_checks++;
    if (busy !== 1'b1 || c11 === '0) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got busy=%0b c11=%h want busy=1 c11!=0", busy, c11);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want 0", dut_vec);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, w[0], 0, 0, 0);
    step(0, 1, w[1], 1, w[2], 0);
    step(0, 0, 0, 1, w[3], 0);
    n_checks++;
    if ({c11, c21, c12, c22} !== {w[0], w[1], w[2], w[3]} || out_valid !== 1'b1 ||
        overflow !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got %h want %h", dut_vec, model_vec());
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom(),
           $urandom_range(0, 1), $urandom(), $urandom_range(0, 1));
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_unskewed();
    test_overflow();
    test_restart();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
